// File: rtl/alu_op_sequencer_if.sv
// ============================================================================
// Module : alu_op_sequencer_if
// Brief  : Request handshake bundle for the ALU operation sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_op_sequencer_if #(
   parameter int AW = 3
);
   logic          valid;
   logic          ready;
   logic [2:0]    op;
   logic [AW-1:0] src_a;
   logic [AW-1:0] src_b;
   logic [AW-1:0] dst;

   modport master (
      output valid, op, src_a, src_b, dst,
      input  ready
   );

   modport slave (
      input  valid, op, src_a, src_b, dst,
      output ready
   );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Issue stage for a registered ALU: reads operands from an internal
//          register file, drives the ALU, writes the result back.
//          Optional zero flag enabled by macro ALU_SEQ_ZFLAG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
   parameter int NREGS = 8,
   parameter int DW    = 32
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   alu_op_sequencer_if.slave             req,
   output logic [DW-1:0]                 alu_a,
   output logic [DW-1:0]                 alu_b,
   output logic [2:0]                    alu_ctrl,
   input  wire logic [DW-1:0]            alu_result,
   output logic                          done,
   output logic [DW-1:0]                 res_data,
   output logic                          zflag,
   input  wire logic                     wr_en,
   input  wire logic [$clog2(NREGS)-1:0] wr_addr,
   input  wire logic [DW-1:0]            wr_data,
   input  wire logic [$clog2(NREGS)-1:0] rd_addr,
   output logic [DW-1:0]                 rd_data
);

   localparam int AW = $clog2(NREGS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          accept;
   logic [AW-1:0] dst_q;
   logic [DW-1:0] rf [NREGS];

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req.ready = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req.ready = 1'b1;
            accept    = req.valid;
            if (req.valid) state_nxt = ISSUE;
         end
         ISSUE: state_nxt = WB;
         WB: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // ALU operand/control registers: held outside of acceptance
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= 3'b000;
         dst_q    <= '0;
      end else if (accept) begin
         alu_a    <= rf[req.src_a];
         alu_b    <= rf[req.src_b];
         alu_ctrl <= req.op;
         dst_q    <= req.dst;
      end
   end

   // ------------------------------------------------------------------------
   // Register file: write-back is placed last so it wins an index collision
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         if (wr_en)       rf[wr_addr] <= wr_data;
         if (state == WB) rf[dst_q]   <= alu_result;
      end
   end

   assign rd_data = rf[rd_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              res_data <= '0;
      else if (state == WB) res_data <= alu_result;
   end

`ifdef ALU_SEQ_ZFLAG_EN
   logic zflag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              zflag_q <= 1'b0;
      else if (state == WB) zflag_q <= (alu_result == '0);
   end

   assign zflag = zflag_q;
`else
   assign zflag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Scoreboard bench for alu_op_sequencer with a registered ALU model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   localparam int DW = 32;

   typedef struct {
      logic [2:0]    dst;
      logic [DW-1:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] alu_a, alu_b, res_data, rd_data, wr_data;
   logic [DW-1:0] alu_result = '0;
   logic [2:0]    alu_ctrl, wr_addr, rd_addr;
   logic          done, zflag, wr_en;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   logic [DW-1:0] model_rf [8];
   exp_t          sbq [$];
   exp_t          pend;
   bit            pend_valid = 0;
   bit            prev_done = 0;

   alu_op_sequencer_if #(.AW(3)) req_if ();

   alu_op_sequencer #(.NREGS(8), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req_if.slave),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .done       (done),
      .res_data   (res_data),
      .zflag      (zflag),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [DW-1:0] alu_f(input logic [2:0] op,
                                           input logic [DW-1:0] a, b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return ~a;
         default: return '0;
      endcase
   endfunction

   // Registered ALU: captures operands at every edge
   always @(posedge clk) alu_result <= alu_f(alu_ctrl, alu_a, alu_b);

   task automatic chk(input string tag, input logic [DW-1:0] got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic exp_z(input logic [DW-1:0] v);
`ifdef ALU_SEQ_ZFLAG_EN
      return (v == '0);
`else
      return 1'b0;
`endif
   endfunction

   // Done monitor: pops the scoreboard, checks result one cycle later
   always @(negedge clk) begin
      if (rst) begin
         pend_valid = 0;
         prev_done  = 0;
      end else begin
         if (done && prev_done) chk("done_width", 1, 0);
         if (done) begin
            done_cnt++;
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               pend = sbq.pop_front();
               model_rf[pend.dst] = pend.val;
               pend_valid = 1;
            end
         end else if (pend_valid) begin
            chk("res_data", res_data, pend.val);
            chk("zflag", {31'b0, zflag}, {31'b0, exp_z(pend.val)});
            pend_valid = 0;
         end
         prev_done = done;
      end
   end

   task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model_rf[a] = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic push_exp(input logic [2:0] op, a, b, d);
      exp_t e;
      e.dst = d;
      e.val = alu_f(op, model_rf[a], model_rf[b]);
      sbq.push_back(e);
   endtask

   // Returns 1 ns after the acceptance edge
   task automatic issue(input logic [2:0] op, a, b, d);
      int n = 0;
      bit got = 0;
      req_if.valid = 1'b1; req_if.op = op;
      req_if.src_a = a; req_if.src_b = b; req_if.dst = d;
      while (!got && n < 20) begin
         @(negedge clk);
         if (req_if.ready) begin
            push_exp(op, a, b, d);
            got = 1;
         end
         n++;
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      req_if.valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sbq.size() != 0 || pend_valid) && n < 50) begin
         @(posedge clk); n++;
      end
      if (n >= 50) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a);
      rd_addr = a; #1;
      chk(tag, rd_data, model_rf[a]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sbq.delete();
      for (int i = 0; i < 8; i++) model_rf[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int c0, c1, acc;
      wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
      req_if.valid = 0; req_if.op = 0; req_if.src_a = 0;
      req_if.src_b = 0; req_if.dst = 0;
      do_reset();

      @(negedge clk);
      chk("rst_ready", {31'b0, req_if.ready}, 1);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_ctrl", {29'b0, alu_ctrl}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_res", res_data, 0);
      chk("rst_zflag", {31'b0, zflag}, 0);
      for (int i = 0; i < 8; i++) rd_check("rst_rf", 3'(i));

      // Add with handshake timing
      host_write(3'd1, 32'd5);
      host_write(3'd2, 32'd7);
      issue(3'b000, 3'd1, 3'd2, 3'd3);
      chk("alu_a_e0", alu_a, 32'd5);
      chk("alu_b_e0", alu_b, 32'd7);
      @(negedge clk);
      chk("ready_low1", {31'b0, req_if.ready}, 0);
      chk("done_e0", {31'b0, done}, 0);
      @(negedge clk);
      chk("ready_low2", {31'b0, req_if.ready}, 0);
      chk("done_e1", {31'b0, done}, 1);
      @(negedge clk);
      chk("ready_back", {31'b0, req_if.ready}, 1);
      wait_done();
      rd_check("add_r3", 3'd3);
      chk("add_r3_const", rd_data, 32'd12);

      // Subtract wrap
      host_write(3'd1, 32'd0);
      host_write(3'd2, 32'd1);
      issue(3'b001, 3'd1, 3'd2, 3'd4);
      wait_done();
      rd_check("sub_r4", 3'd4);
      chk("sub_r4_const", rd_data, 32'hFFFF_FFFF);

      // Back-to-back with valid held: r3 = 12 -> 24 -> 48
      req_if.valid = 1'b1; req_if.op = 3'b000;
      req_if.src_a = 3'd3; req_if.src_b = 3'd3; req_if.dst = 3'd3;
      acc = 0; c0 = 0; c1 = 0;
      for (int n = 0; n < 20 && acc < 2; n++) begin
         @(negedge clk);
         if (req_if.ready) begin
            push_exp(3'b000, 3'd3, 3'd3, 3'd3);
            if (acc == 0) c0 = cyc; else c1 = cyc;
            acc++;
         end
      end
      @(posedge clk); #1;
      req_if.valid = 1'b0;
      chk("b2b_accepts", acc, 2);
      chk("b2b_spacing", c1 - c0, 3);
      wait_done();
      rd_check("b2b_r3", 3'd3);
      chk("b2b_r3_const", rd_data, 32'd48);

      // Host write collides with write-back to r5
      host_write(3'd1, 32'h1234);
      host_write(3'd2, 32'h0);
      issue(3'b011, 3'd1, 3'd2, 3'd5);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hAAAA;
      model_rf[5] = 32'hAAAA;
      @(posedge clk); #1;
      wr_en = 1'b0;
      wait_done();
      rd_check("collide_r5", 3'd5);
      chk("collide_r5_const", rd_data, 32'h1234);

      // Reset during ISSUE
      host_write(3'd1, 32'd3);
      host_write(3'd2, 32'd4);
      issue(3'b000, 3'd1, 3'd2, 3'd6);
      c0 = done_cnt;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt, c0);
      chk("midrst_ready", {31'b0, req_if.ready}, 1);
      for (int i = 0; i < 8; i++) rd_check("midrst_rf", 3'(i));

      // Zero result
      host_write(3'd1, 32'hF0);
      host_write(3'd2, 32'h0F);
      issue(3'b010, 3'd1, 3'd2, 3'd7);
      wait_done();
      rd_check("and_r7", 3'd7);
      chk("and_zflag", {31'b0, zflag}, {31'b0, exp_z(32'd0)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
